sonar_drive_sched: RTL

SONAR_DRIVE_SCHED -- requirements
Module: sonar_drive_sched

---
 rtl/sonar_drive_sched.sv | 278 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sonar_drive_sched.sv
// sonar_drive_sched
//   Ultrasonic ranging scheduler plus drive-mode sequencer.
//   The sonar side fires a trigger pulse every PERIOD_CYCLES, measures the
//   echo width and flags obstacles closer than NEAR_CYCLES.  The drive side
//   follows key commands and performs a timed left turn when a near obstacle
//   is reported while driving forward.
//
// Ports
//   clk0        : sole clock, rising edge
//   rst         : synchronous active-high reset
//   echo        : asynchronous echo input from the ranging sensor
//   key[3:0]    : active-low keys (1110 right, 1101 fwd, 1011 left, 0111 stop)
//   trig        : trigger pulse to the sensor
//   mode[1:0]   : motor mode (00 stop, 01 fwd, 10 left, 11 right)
//   meas_cycles : last completed echo width in clk0 cycles
//   meas_valid  : one-cycle pulse when meas_cycles updates
//   near        : meas_cycles <= NEAR_CYCLES for the last valid measurement
//   timeout_err : one-cycle pulse when a measurement times out
module sonar_drive_sched #(
    parameter int unsigned TRIG_CYCLES    = 500,
    parameter int unsigned PERIOD_CYCLES  = 3000000,
    parameter int unsigned TIMEOUT_CYCLES = 1500000,
    parameter int unsigned NEAR_CYCLES    = 44117,
    parameter int unsigned TURN_CYCLES    = 25000000
) (
    input  logic        clk0,
    input  logic        rst,
    input  logic        echo,
    input  logic [3:0]  key,
    output logic        trig,
    output logic [1:0]  mode,
    output logic [21:0] meas_cycles,
    output logic        meas_valid,
    output logic        near,
    output logic        timeout_err
);

    // ------------------------------------------------------------------
    // Input synchronizers: bit 4 is echo, bits 3:0 are the keys.
    // ------------------------------------------------------------------
    logic [4:0] async_in;
    logic [4:0] sync1_reg;
    logic [4:0] sync2_reg;

    assign async_in = {echo, key};

    genvar gi;
    generate
        for (gi = 0; gi < 5; gi++) begin : g_sync
            always_ff @(posedge clk0) begin
                if (rst) begin
                    sync1_reg[gi] <= 1'b0;
                    sync2_reg[gi] <= 1'b0;
                end else begin
                    sync1_reg[gi] <= async_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    logic       echo_s;
    logic [3:0] key_s;
    logic       echo_prev_reg;
    logic [3:0] key_prev_reg;
    logic       echo_rise;

    assign echo_s    = sync2_reg[4];
    assign key_s     = sync2_reg[3:0];
    assign echo_rise = echo_s & ~echo_prev_reg;

    // ------------------------------------------------------------------
    // Sonar FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_DONE
    } sonar_state_t;

    sonar_state_t sonar_state_reg, sonar_state_next;
    logic [31:0]  period_cnt_reg, period_cnt_next;
    // Shared by TRIG (pulse width) and WAIT_RISE (rise timeout); the two
    // states never overlap so one counter is enough.
    logic [31:0]  phase_cnt_reg, phase_cnt_next;
    logic [21:0]  width_reg, width_next;
    logic [21:0]  width_inc;
    // Set by reset so the first trigger fires on the first edge after
    // release instead of waiting a full period.
    logic         kick_reg, kick_next;
    logic         done_pulse;
    logic         timeout_pulse;

    assign width_inc = (width_reg == 22'h3F_FFFF) ? width_reg : width_reg + 22'd1;

    always_comb begin
        sonar_state_next = sonar_state_reg;
        period_cnt_next  = (period_cnt_reg >= PERIOD_CYCLES - 1) ? period_cnt_reg
                                                                 : period_cnt_reg + 32'd1;
        phase_cnt_next   = phase_cnt_reg;
        width_next       = width_reg;
        kick_next        = kick_reg;
        done_pulse       = 1'b0;
        timeout_pulse    = 1'b0;

        case (sonar_state_reg)
            S_IDLE: begin
                if (kick_reg || (period_cnt_reg >= PERIOD_CYCLES - 1)) begin
                    sonar_state_next = S_TRIG;
                    period_cnt_next  = 32'd0;
                    phase_cnt_next   = 32'd0;
                    kick_next        = 1'b0;
                end
            end
            S_TRIG: begin
                if (phase_cnt_reg >= TRIG_CYCLES - 1) begin
                    sonar_state_next = S_WAIT_RISE;
                    phase_cnt_next   = 32'd0;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 32'd1;
                end
            end
            S_WAIT_RISE: begin
                if (echo_rise) begin
                    // The rise cycle itself is the first high cycle.
                    sonar_state_next = S_MEASURE;
                    width_next       = 22'd1;
                end else if (phase_cnt_reg >= TIMEOUT_CYCLES - 1) begin
                    sonar_state_next = S_IDLE;
                    timeout_pulse    = 1'b1;
                end else begin
                    phase_cnt_next = phase_cnt_reg + 32'd1;
                end
            end
            S_MEASURE: begin
                if (!echo_s) begin
                    sonar_state_next = S_DONE;
                end else begin
                    width_next = width_inc;
                    if ({10'd0, width_inc} >= TIMEOUT_CYCLES) begin
                        sonar_state_next = S_IDLE;
                        timeout_pulse    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                done_pulse       = 1'b1;
                sonar_state_next = S_IDLE;
            end
            default: begin
                sonar_state_next = S_IDLE;
            end
        endcase
    end

    logic [21:0] meas_cycles_reg;
    logic        meas_valid_reg;
    logic        near_reg;
    logic        timeout_err_reg;

    always_ff @(posedge clk0) begin
        if (rst) begin
            sonar_state_reg <= S_IDLE;
            period_cnt_reg  <= 32'd0;
            phase_cnt_reg   <= 32'd0;
            width_reg       <= 22'd0;
            kick_reg        <= 1'b1;
            echo_prev_reg   <= 1'b0;
            meas_cycles_reg <= 22'd0;
            meas_valid_reg  <= 1'b0;
            near_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
        end else begin
            sonar_state_reg <= sonar_state_next;
            period_cnt_reg  <= period_cnt_next;
            phase_cnt_reg   <= phase_cnt_next;
            width_reg       <= width_next;
            kick_reg        <= kick_next;
            echo_prev_reg   <= echo_s;
            meas_valid_reg  <= done_pulse;
            timeout_err_reg <= timeout_pulse;
            if (done_pulse) begin
                meas_cycles_reg <= width_reg;
                near_reg        <= ({10'd0, width_reg} <= NEAR_CYCLES);
            end
        end
    end

    assign trig        = (sonar_state_reg == S_TRIG);
    assign meas_cycles = meas_cycles_reg;
    assign meas_valid  = meas_valid_reg;
    assign near        = near_reg;
    assign timeout_err = timeout_err_reg;

    // ------------------------------------------------------------------
    // Drive FSM
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        D_STOP,
        D_FWD,
        D_LEFT,
        D_RIGHT,
        D_AVOID
    } drive_state_t;

    drive_state_t drive_state_reg, drive_state_next;
    logic [31:0]  turn_cnt_reg, turn_cnt_next;
    logic         key_valid;
    logic         key_cmd;

    assign key_valid = (key_s == 4'b1110) || (key_s == 4'b1101) ||
                       (key_s == 4'b1011) || (key_s == 4'b0111);
    // Edge-qualified so a held key issues one command only.
    assign key_cmd   = key_valid && (key_s != key_prev_reg);

    always_comb begin
        drive_state_next = drive_state_reg;
        turn_cnt_next    = turn_cnt_reg;

        if (key_cmd) begin
            // Key commands take priority over any obstacle decision.
            case (key_s)
                4'b1110: drive_state_next = D_RIGHT;
                4'b1101: drive_state_next = D_FWD;
                4'b1011: drive_state_next = D_LEFT;
                default: drive_state_next = D_STOP;
            endcase
        end else begin
            case (drive_state_reg)
                D_FWD: begin
                    // Timeouts never raise meas_valid, so they count as clear.
                    if (meas_valid_reg && near_reg) begin
                        drive_state_next = D_AVOID;
                        turn_cnt_next    = TURN_CYCLES;
                    end
                end
                D_AVOID: begin
                    // Leave on the cycle the decremented timer reaches zero,
                    // giving exactly TURN_CYCLES cycles of turning.
                    if (turn_cnt_reg != 32'd0) begin
                        turn_cnt_next = turn_cnt_reg - 32'd1;
                    end
                    if (turn_cnt_reg <= 32'd1) begin
                        drive_state_next = D_FWD;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk0) begin
        if (rst) begin
            drive_state_reg <= D_STOP;
            turn_cnt_reg    <= 32'd0;
            key_prev_reg    <= 4'd0;
        end else begin
            drive_state_reg <= drive_state_next;
            turn_cnt_reg    <= turn_cnt_next;
            key_prev_reg    <= key_s;
        end
    end

    always_comb begin
        mode = 2'b00;
        case (drive_state_reg)
            D_FWD:   mode = 2'b01;
            D_LEFT:  mode = 2'b10;
            D_RIGHT: mode = 2'b11;
            D_AVOID: mode = 2'b10;
            default: mode = 2'b00;
        endcase
    end

endmodule
